// File: rtl/symbol_conditioner.sv
// Push-button conditioner feeding the sequence detector's x1/x0 inputs:
// two-flop sync, per-bit debounce, and a framer that emits one symbol per press.
module symbol_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COMBINE_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn1,
   input  logic       btn0,
   output logic       x1,
   output logic       x0,
   output logic       sym_valid,
   output logic [7:0] sym_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = $clog2(COMBINE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      COMBINE,
      HOLD
   } state_t;

   logic [1:0] meta;
   logic [1:0] sync;
   logic [1:0] deb;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {btn1, btn0};
         sync <= meta;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
            q   <= 1'b0;
         end else if (sync[i] == q) begin
            cnt <= '0;
         end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            q   <= sync[i];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign deb[i] = q;
   end

   state_t        state;
   state_t        state_nx;
   logic [1:0]    acc;
   logic [1:0]    acc_nx;
   logic [1:0]    sym;
   logic [1:0]    sym_nx;
   logic [CW-1:0] ccnt;
   logic [CW-1:0] ccnt_nx;
   logic          enter_hold;

   always_comb begin
      state_nx   = state;
      acc_nx     = acc;
      sym_nx     = sym;
      ccnt_nx    = ccnt;
      enter_hold = 1'b0;
      unique case (state)
         IDLE: begin
            if (deb != 2'b00) begin
               acc_nx   = deb;
               ccnt_nx  = '0;
               state_nx = COMBINE;
            end
         end
         COMBINE: begin
            acc_nx = acc | deb;
            if (ccnt == CW'(COMBINE_CYCLES - 1)) begin
               sym_nx     = acc | deb;
               state_nx   = HOLD;
               enter_hold = 1'b1;
            end else begin
               ccnt_nx = ccnt + 1'b1;
            end
         end
         HOLD: begin
            // late bits are ignored; only a full release ends the symbol
            if (deb == 2'b00) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         acc   <= '0;
         sym   <= '0;
         ccnt  <= '0;
      end else begin
         state <= state_nx;
         acc   <= acc_nx;
         sym   <= sym_nx;
         ccnt  <= ccnt_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x1        <= 1'b0;
         x0        <= 1'b0;
         sym_valid <= 1'b0;
         sym_count <= '0;
      end else begin
         {x1, x0}  <= (state_nx == HOLD) ? sym_nx : 2'b00;
         sym_valid <= enter_hold;
         sym_count <= sym_count + {7'd0, enter_hold};
      end
   end

endmodule

// File: tb/tb_symbol_conditioner.sv
// Self-checking bench for symbol_conditioner: directed scenarios plus
// randomized presses checked against a timing/merge model of the framer.
module tb_symbol_conditioner;

   localparam int D   = 4;
   localparam int C   = 8;
   localparam int LAT = 3 + D + C;
   localparam int REL = 3 + D;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn1 = 1'b1;
   logic       btn0 = 1'b1;
   logic       x1;
   logic       x0;
   logic       sym_valid;
   logic [7:0] sym_count;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_count = 8'd0;

   int         v_cnt;
   int         v_edge;
   logic [1:0] v_sym;
   int         first_nz;
   int         last_nz;
   int         bad_nz;

   symbol_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .COMBINE_CYCLES (C)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn1     (btn1),
      .btn0     (btn0),
      .x1       (x1),
      .x0       (x0),
      .sym_valid(sym_valid),
      .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   // Button b is high in the interval after edge r_b up to edge f_b
   // (r_b < 0 means never pressed). Called just after a sample point.
   task automatic run_window(input int r1, input int f1,
                             input int r0, input int f0,
                             input int total);
      v_cnt    = 0;
      v_edge   = -1;
      v_sym    = 2'b00;
      first_nz = -1;
      last_nz  = -1;
      bad_nz   = 0;
      for (int e = 1; e <= total; e++) begin
         btn1 = (r1 >= 0 && e - 1 >= r1 && e - 1 < f1);
         btn0 = (r0 >= 0 && e - 1 >= r0 && e - 1 < f0);
         @(posedge clk);
         #1;
         if (sym_valid) begin
            v_cnt++;
            if (v_edge < 0) begin
               v_edge = e;
               v_sym  = {x1, x0};
            end
         end
         if ({x1, x0} != 2'b00) begin
            if (first_nz < 0) first_nz = e;
            last_nz = e;
            if ({x1, x0} !== v_sym) bad_nz++;
         end
      end
      btn1 = 1'b0;
      btn0 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({x1, x0, sym_valid} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outs: got %b want 000", {x1, x0, sym_valid});
      end
      checks++;
      if (sym_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_count: got %0d want 0", sym_count);
      end
      reset = 1'b1;
      run_window(0, 20, 0, 20, 30);
      exp_count = exp_count + 8'd1;
      checks++;
      if (v_edge != LAT || v_sym !== 2'b11 || v_cnt != 1) begin
         failures++;
         $display("FAIL reset_release_sym: got edge=%0d sym=%b n=%0d want edge=%0d sym=11 n=1",
                  v_edge, v_sym, v_cnt, LAT);
      end
      checks++;
      if (sym_count !== exp_count) begin
         failures++;
         $display("FAIL reset_release_count: got %0d want %0d", sym_count, exp_count);
      end
   endtask

   task automatic test_single();
      run_window(-1, 0, 0, 30, 40);
      exp_count = exp_count + 8'd1;
      checks++;
      if (v_sym !== 2'b01 || v_cnt != 1 || v_edge != LAT) begin
         failures++;
         $display("FAIL single_sym: got sym=%b n=%0d edge=%0d want 01 1 %0d",
                  v_sym, v_cnt, v_edge, LAT);
      end
      checks++;
      if (first_nz != LAT || last_nz != 30 + REL - 1 || bad_nz != 0) begin
         failures++;
         $display("FAIL single_span: got %0d..%0d bad=%0d want %0d..%0d bad=0",
                  first_nz, last_nz, bad_nz, LAT, 30 + REL - 1);
      end
      checks++;
      if (sym_count !== exp_count) begin
         failures++;
         $display("FAIL single_count: got %0d want %0d", sym_count, exp_count);
      end
   endtask

   task automatic test_glitch();
      run_window(0, 3, -1, 0, 20);
      checks++;
      if (v_cnt != 0 || first_nz != -1 || sym_count !== exp_count) begin
         failures++;
         $display("FAIL glitch: got n=%0d nz=%0d cnt=%0d want 0 -1 %0d",
                  v_cnt, first_nz, sym_count, exp_count);
      end
   endtask

   task automatic test_combine();
      run_window(0, 40, 5, 40, 50);
      exp_count = exp_count + 8'd1;
      checks++;
      if (v_sym !== 2'b11 || v_cnt != 1 || bad_nz != 0) begin
         failures++;
         $display("FAIL combine_in: got sym=%b n=%0d bad=%0d want 11 1 0",
                  v_sym, v_cnt, bad_nz);
      end
      run_window(0, 40, 20, 40, 50);
      exp_count = exp_count + 8'd1;
      checks++;
      if (v_sym !== 2'b10 || v_cnt != 1 || bad_nz != 0) begin
         failures++;
         $display("FAIL combine_late: got sym=%b n=%0d bad=%0d want 10 1 0",
                  v_sym, v_cnt, bad_nz);
      end
      checks++;
      if (sym_count !== exp_count) begin
         failures++;
         $display("FAIL combine_count: got %0d want %0d", sym_count, exp_count);
      end
   endtask

   task automatic test_sequence();
      logic [1:0] seq [5];
      seq = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
      for (int i = 0; i < 5; i++) begin
         run_window(seq[i][1] ? 0 : -1, 20, seq[i][0] ? 0 : -1, 20, 30);
         exp_count = exp_count + 8'd1;
         checks++;
         if (v_sym !== seq[i] || v_cnt != 1 || first_nz != LAT ||
             last_nz != 20 + REL - 1 || bad_nz != 0) begin
            failures++;
            $display("FAIL seq_%0d: got sym=%b n=%0d span=%0d..%0d bad=%0d want %b",
                     i, v_sym, v_cnt, first_nz, last_nz, bad_nz, seq[i]);
         end
      end
      checks++;
      if (sym_count !== exp_count) begin
         failures++;
         $display("FAIL seq_count: got %0d want %0d", sym_count, exp_count);
      end
   endtask

   task automatic test_random();
      int rs [2];
      int fs [2];
      int b;
      int o;
      int mode;
      int maxf;
      logic [1:0] esym;
      for (int n = 0; n < 24; n++) begin
         mode = $urandom_range(0, 3);
         if (mode == 0) begin
            rs[1] = $urandom_range(0, 3);
            fs[1] = rs[1] + $urandom_range(1, D - 1);
            rs[0] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
            fs[0] = rs[0] + $urandom_range(1, D - 1);
            run_window(rs[1], fs[1], rs[0], fs[0], 20);
            checks++;
            if (v_cnt != 0 || first_nz != -1) begin
               failures++;
               $display("FAIL rnd_glitch_%0d: got n=%0d nz=%0d want 0 -1",
                        n, v_cnt, first_nz);
            end
         end else begin
            b = $urandom_range(0, 1);
            o = 1 - b;
            rs[b] = 0;
            fs[b] = $urandom_range(C + 14, C + 24);
            rs[o] = -1;
            fs[o] = 0;
            if (mode == 2) rs[o] = $urandom_range(0, C - 2);
            if (mode == 3) rs[o] = $urandom_range(C + 3, C + 10);
            if (rs[o] >= 0) fs[o] = rs[o] + $urandom_range(D + 1, 20);
            esym    = 2'b00;
            esym[b] = 1'b1;
            esym[o] = (rs[o] >= 0 && rs[o] <= C);
            maxf    = (fs[o] > fs[b]) ? fs[o] : fs[b];
            run_window(rs[1], fs[1], rs[0], fs[0], maxf + REL + 4);
            exp_count = exp_count + 8'd1;
            checks++;
            if (v_sym !== esym || v_cnt != 1 || first_nz != LAT ||
                last_nz != maxf + REL - 1 || bad_nz != 0) begin
               failures++;
               $display("FAIL rnd_press_%0d: got sym=%b n=%0d span=%0d..%0d bad=%0d want %b 1 %0d..%0d",
                        n, v_sym, v_cnt, first_nz, last_nz, bad_nz,
                        esym, LAT, maxf + REL - 1);
            end
         end
      end
      checks++;
      if (sym_count !== exp_count) begin
         failures++;
         $display("FAIL rnd_count: got %0d want %0d", sym_count, exp_count);
      end
   endtask

   task automatic test_wrap();
      while (exp_count != 8'd255) begin
         run_window(-1, 0, 0, C + 3, C + 3 + REL + 4);
         exp_count = exp_count + 8'd1;
      end
      checks++;
      if (sym_count !== 8'd255) begin
         failures++;
         $display("FAIL wrap_255: got %0d want 255", sym_count);
      end
      run_window(-1, 0, 0, C + 3, C + 3 + REL + 4);
      exp_count = exp_count + 8'd1;
      checks++;
      if (sym_count !== exp_count || v_cnt != 1) begin
         failures++;
         $display("FAIL wrap_0: got %0d n=%0d want %0d 1", sym_count, v_cnt, exp_count);
      end
   endtask

   task automatic test_reset_mid();
      btn1 = 1'b1;
      btn0 = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      checks++;
      if ({x1, x0} !== 2'b10) begin
         failures++;
         $display("FAIL mid_hold: got %b want 10", {x1, x0});
      end
      #2;
      reset = 1'b0;
      #1;
      exp_count = 8'd0;
      checks++;
      if ({x1, x0, sym_valid} !== 3'b000 || sym_count !== 8'd0) begin
         failures++;
         $display("FAIL mid_async: got %b cnt=%0d want 000 0",
                  {x1, x0, sym_valid}, sym_count);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      run_window(0, 25, -1, 0, 35);
      exp_count = exp_count + 8'd1;
      checks++;
      if (v_edge != LAT || v_sym !== 2'b10 || v_cnt != 1 ||
          sym_count !== exp_count) begin
         failures++;
         $display("FAIL mid_after: got edge=%0d sym=%b n=%0d cnt=%0d want %0d 10 1 %0d",
                  v_edge, v_sym, v_cnt, sym_count, LAT, exp_count);
      end
   endtask

   initial begin
      fork
         begin
            test_reset();
            test_single();
            test_glitch();
            test_combine();
            test_sequence();
            test_random();
            test_wrap();
            test_reset_mid();
         end
         begin
            #2_000_000;
            failures++;
            $display("FAIL timeout: got no completion want completion");
         end
      join_any
      disable fork;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
